// File: rtl/riscv_defines_pkg.sv
// riscv_defines: shared decode definitions for the integer pipeline.
//   - opcode / funct3 / funct7 constants
//   - alu_op_t ALU operation encoding
//   - control_signals_t decoded control bundle (all-zero == no-op / bubble)
//   - id_ex_payload_t, the ID/EX pipeline register contents at default width
// Used by id_ex_reg and hazard_unit. The optional load-use interlock in
// id_ex_reg is enabled with the LOAD_USE_INTERLOCK_EN macro.
package riscv_defines;

  localparam int XLEN_DEF = 32;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_LW      = 3'b010;
  localparam logic [2:0] F3_SW      = 3'b010;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9,
    ALU_PASS = 4'd10
  } alu_op_t;

  // Write-back source select; WB_MEM marks a load result, which is what
  // the load-use interlock keys on.
  localparam logic [1:0] WB_MEM = 2'b00;
  localparam logic [1:0] WB_ALU = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] WB_IMM = 2'b11;

  typedef struct packed {
    logic       reg_wen;
    logic       mem_req;
    logic       mem_rw;    // 1 = store
    logic [1:0] wb_sel;
    logic       alu_src;   // 1 = immediate operand
    logic       branch;
    logic       jump;
    alu_op_t    alu_op;
  } control_signals_t;

  localparam control_signals_t CTRL_NOP = '0;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [XLEN_DEF-1:0] rs1_data;
    logic [XLEN_DEF-1:0] rs2_data;
    logic [XLEN_DEF-1:0] imm;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [4:0]          rd;
    logic [2:0]          funct3;
    control_signals_t    ctrl;
  } id_ex_payload_t;

  // True when the instruction writes a register from memory (a load).
  function automatic logic is_load_wb(input logic reg_wen, input logic [1:0] wb_sel);
    return reg_wen && (wb_sel == WB_MEM);
  endfunction

endpackage

// File: rtl/id_ex_reg_hazard_unit.sv
// hazard_unit: load-use interlock detection and bubble counter.
// Only instantiated by id_ex_reg when LOAD_USE_INTERLOCK_EN is defined.
// Ports:
//   clk, rst                     clock, async active-high reset
//   ex_valid, ex_reg_wen,
//   ex_wb_sel, ex_rd             instruction currently held in EX
//   id_valid, id_rs1, id_rs2     instruction offered by decode
//   ex_ready, flush              execute consume / pipeline kill
//   hz_stall                     load-use interlock active (combinational)
//   hz_count                     saturating count of inserted bubbles
module hazard_unit
  import riscv_defines::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_reg_wen,
  input  logic [1:0]  ex_wb_sel,
  input  logic [4:0]  ex_rd,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        ex_ready,
  input  logic        flush,
  output logic        hz_stall,
  output logic [15:0] hz_count
);

  // rs1/rs2 are compared even for formats that do not read them; a spurious
  // bubble is harmless, a missed one is not.
  assign hz_stall = ex_valid && is_load_wb(ex_reg_wen, ex_wb_sel) &&
                    (ex_rd != 5'd0) && id_valid &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hz_count <= '0;
    end else if (hz_stall && ex_ready && !flush && (hz_count != 16'hFFFF)) begin
      hz_count <= hz_count + 16'd1;
    end
  end

endmodule

// File: rtl/id_ex_reg.sv
// id_ex_reg: single-entry ID/EX pipeline register with valid/ready handshake,
// flush, and an optional load-use interlock (macro LOAD_USE_INTERLOCK_EN).
// Ports:
//   clk, rst                          clock, async active-high reset
//   id_valid / id_ready               decode handshake (id_ready combinational)
//   id_pc, id_rs1_data, id_rs2_data,
//   id_imm, id_rs1, id_rs2, id_rd,
//   id_funct3, id_ctrl                decode payload
//   flush                             kill held and offered instruction
//   ex_ready / ex_valid               execute handshake
//   ex_*                              registered payload to execute
//   hz_stall, hz_count                interlock status (0 when macro undefined)
module id_ex_reg
  import riscv_defines::*;
#(
  parameter int XLEN = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  output logic             id_ready,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic [2:0]       id_funct3,
  input  control_signals_t id_ctrl,
  input  logic             flush,
  input  logic             ex_ready,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [2:0]       ex_funct3,
  output control_signals_t ex_ctrl,
  output logic             hz_stall,
  output logic [15:0]      hz_count
);

  logic capture;
  logic load_bubble;

`ifdef LOAD_USE_INTERLOCK_EN
  hazard_unit u_hazard (
    .clk        (clk),
    .rst        (rst),
    .ex_valid   (ex_valid),
    .ex_reg_wen (ex_ctrl.reg_wen),
    .ex_wb_sel  (ex_ctrl.wb_sel),
    .ex_rd      (ex_rd),
    .id_valid   (id_valid),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .ex_ready   (ex_ready),
    .flush      (flush),
    .hz_stall   (hz_stall),
    .hz_count   (hz_count)
  );
`else
  assign hz_stall = 1'b0;
  assign hz_count = 16'd0;
`endif

  assign id_ready = (!ex_valid || ex_ready) && !hz_stall;

  assign capture = id_valid && id_ready && !flush;
  // An empty register reloads a bubble as well; that keeps ex_ctrl zero
  // whenever ex_valid is low.
  assign load_bubble = flush || (!capture && (ex_ready || !ex_valid));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_funct3   <= '0;
      ex_ctrl     <= CTRL_NOP;
    end else if (load_bubble) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_funct3   <= '0;
      ex_ctrl     <= CTRL_NOP;
    end else if (capture) begin
      ex_valid    <= 1'b1;
      ex_pc       <= id_pc;
      ex_rs1_data <= id_rs1_data;
      ex_rs2_data <= id_rs2_data;
      ex_imm      <= id_imm;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_rd       <= id_rd;
      ex_funct3   <= id_funct3;
      ex_ctrl     <= id_ctrl;
    end
  end

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed testbench for id_ex_reg. Expected values follow the load-use
// interlock configuration selected by LOAD_USE_INTERLOCK_EN.
module tb_id_ex_reg;
  import riscv_defines::*;

  logic             clk;
  logic             rst;
  logic             id_valid;
  logic             id_ready;
  logic [31:0]      id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]       id_rs1, id_rs2, id_rd;
  logic [2:0]       id_funct3;
  control_signals_t id_ctrl;
  logic             flush;
  logic             ex_ready;
  logic             ex_valid;
  logic [31:0]      ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]       ex_rs1, ex_rs2, ex_rd;
  logic [2:0]       ex_funct3;
  control_signals_t ex_ctrl;
  logic             hz_stall;
  logic [15:0]      hz_count;

  int tests = 0;
  int fails = 0;

  control_signals_t c_add;
  control_signals_t c_lw;

  id_ex_reg #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3),
    .id_ctrl(id_ctrl), .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
    .ex_ctrl(ex_ctrl), .hz_stall(hz_stall), .hz_count(hz_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic [2:0] f3, input control_signals_t c,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
    id_valid    = 1'b1;
    id_pc       = pc;
    id_rs1      = rs1;
    id_rs2      = rs2;
    id_rd       = rd;
    id_funct3   = f3;
    id_ctrl     = c;
    id_rs1_data = a;
    id_rs2_data = b;
    id_imm      = imm;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    tests++; if (ex_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0b want 0", ex_valid); end
    tests++; if (ex_pc !== 32'h0) begin fails++; $display("FAIL reset_pc: got %h want 0", ex_pc); end
    tests++; if (ex_ctrl !== CTRL_NOP) begin fails++; $display("FAIL reset_ctrl: got %h want 0", ex_ctrl); end
    tests++; if (id_ready !== 1'b1) begin fails++; $display("FAIL reset_id_ready: got %0b want 1", id_ready); end
    tests++; if (hz_stall !== 1'b0) begin fails++; $display("FAIL reset_hz_stall: got %0b want 0", hz_stall); end
    tests++; if (hz_count !== 16'd0) begin fails++; $display("FAIL reset_hz_count: got %0d want 0", hz_count); end
    rst = 1'b0;
  endtask

  task automatic test_add();
    offer(32'h100, 5'd1, 5'd2, 5'd3, F3_ADD_SUB, c_add, 32'd7, 32'd9, 32'd0);
    ex_ready = 1'b1;
    #1;
    tests++; if (id_ready !== 1'b1) begin fails++; $display("FAIL add_id_ready: got %0b want 1", id_ready); end
    tick();
    tests++; if (ex_valid !== 1'b1) begin fails++; $display("FAIL add_valid: got %0b want 1", ex_valid); end
    tests++; if (ex_pc !== 32'h100) begin fails++; $display("FAIL add_pc: got %h want 100", ex_pc); end
    tests++; if (ex_rd !== 5'd3) begin fails++; $display("FAIL add_rd: got %0d want 3", ex_rd); end
    tests++; if (ex_ctrl.alu_op !== ALU_ADD) begin fails++; $display("FAIL add_alu_op: got %0d want %0d", ex_ctrl.alu_op, ALU_ADD); end
    tests++; if (ex_rs2_data !== 32'd9) begin fails++; $display("FAIL add_rs2_data: got %0d want 9", ex_rs2_data); end
    tests++; if (ex_ctrl !== c_add) begin fails++; $display("FAIL add_ctrl: got %h want %h", ex_ctrl, c_add); end
    id_valid = 1'b0;
    tick();
    tests++; if (ex_valid !== 1'b0) begin fails++; $display("FAIL idle_bubble_valid: got %0b want 0", ex_valid); end
    tests++; if (ex_ctrl !== CTRL_NOP) begin fails++; $display("FAIL idle_bubble_ctrl: got %h want 0", ex_ctrl); end
    tests++; if (ex_rd !== 5'd0) begin fails++; $display("FAIL idle_bubble_rd: got %0d want 0", ex_rd); end
  endtask

  task automatic test_backpressure();
    offer(32'h200, 5'd1, 5'd2, 5'd7, F3_ADD_SUB, c_add, 32'd1, 32'd2, 32'd0);
    ex_ready = 1'b1;
    tick();
    offer(32'h204, 5'd3, 5'd4, 5'd8, F3_ADD_SUB, c_add, 32'd3, 32'd4, 32'd0);
    ex_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if (id_ready !== 1'b0) begin fails++; $display("FAIL bp_id_ready[%0d]: got %0b want 0", i, id_ready); end
      tick();
      tests++; if (ex_pc !== 32'h200 || ex_rd !== 5'd7 || ex_valid !== 1'b1)
        begin fails++; $display("FAIL bp_hold[%0d]: got pc=%h rd=%0d v=%0b want pc=200 rd=7 v=1", i, ex_pc, ex_rd, ex_valid); end
    end
    ex_ready = 1'b1;
    #1;
    tests++; if (id_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready: got %0b want 1", id_ready); end
    tick();
    tests++; if (ex_pc !== 32'h204 || ex_rd !== 5'd8) begin fails++; $display("FAIL bp_accept: got pc=%h rd=%0d want pc=204 rd=8", ex_pc, ex_rd); end
    id_valid = 1'b0;
    tick();
  endtask

  task automatic test_load_use();
    offer(32'h300, 5'd2, 5'd0, 5'd5, F3_LW, c_lw, 32'h1000, 32'd0, 32'd4);
    ex_ready = 1'b1;
    tick();
    offer(32'h304, 5'd5, 5'd1, 5'd6, F3_ADD_SUB, c_add, 32'd0, 32'd1, 32'd0);
    #1;
`ifdef LOAD_USE_INTERLOCK_EN
    tests++; if (hz_stall !== 1'b1) begin fails++; $display("FAIL lu_stall: got %0b want 1", hz_stall); end
    tests++; if (id_ready !== 1'b0) begin fails++; $display("FAIL lu_id_ready: got %0b want 0", id_ready); end
    tick();
    tests++; if (ex_valid !== 1'b0 || ex_ctrl !== CTRL_NOP) begin fails++; $display("FAIL lu_bubble: got v=%0b ctrl=%h want v=0 ctrl=0", ex_valid, ex_ctrl); end
    tests++; if (hz_stall !== 1'b0 || id_ready !== 1'b1) begin fails++; $display("FAIL lu_clear: got stall=%0b ready=%0b want 0 1", hz_stall, id_ready); end
    tick();
    tests++; if (ex_valid !== 1'b1 || ex_rd !== 5'd6 || ex_pc !== 32'h304) begin fails++; $display("FAIL lu_accept: got v=%0b rd=%0d pc=%h want 1 6 304", ex_valid, ex_rd, ex_pc); end
    tests++; if (hz_count !== 16'd1) begin fails++; $display("FAIL lu_count: got %0d want 1", hz_count); end
`else
    tests++; if (hz_stall !== 1'b0 || id_ready !== 1'b1) begin fails++; $display("FAIL lu_nostall: got stall=%0b ready=%0b want 0 1", hz_stall, id_ready); end
    tick();
    tests++; if (ex_valid !== 1'b1 || ex_rd !== 5'd6 || ex_pc !== 32'h304) begin fails++; $display("FAIL lu_direct: got v=%0b rd=%0d pc=%h want 1 6 304", ex_valid, ex_rd, ex_pc); end
    tests++; if (hz_count !== 16'd0) begin fails++; $display("FAIL lu_count: got %0d want 0", hz_count); end
`endif
    id_valid = 1'b0;
    tick();
  endtask

  task automatic test_x0();
    offer(32'h400, 5'd2, 5'd0, 5'd0, F3_LW, c_lw, 32'h2000, 32'd0, 32'd8);
    ex_ready = 1'b1;
    tick();
    tests++; if (ex_valid !== 1'b1 || ex_rd !== 5'd0 || ex_ctrl !== c_lw) begin fails++; $display("FAIL x0_capture: got v=%0b rd=%0d ctrl=%h want 1 0 %h", ex_valid, ex_rd, ex_ctrl, c_lw); end
    offer(32'h404, 5'd0, 5'd0, 5'd7, F3_ADD_SUB, c_add, 32'd0, 32'd0, 32'd0);
    #1;
    tests++; if (hz_stall !== 1'b0 || id_ready !== 1'b1) begin fails++; $display("FAIL x0_nostall: got stall=%0b ready=%0b want 0 1", hz_stall, id_ready); end
    tick();
    tests++; if (ex_valid !== 1'b1 || ex_rd !== 5'd7) begin fails++; $display("FAIL x0_accept: got v=%0b rd=%0d want 1 7", ex_valid, ex_rd); end
`ifdef LOAD_USE_INTERLOCK_EN
    tests++; if (hz_count !== 16'd1) begin fails++; $display("FAIL x0_count: got %0d want 1", hz_count); end
`else
    tests++; if (hz_count !== 16'd0) begin fails++; $display("FAIL x0_count: got %0d want 0", hz_count); end
`endif
    id_valid = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    offer(32'h500, 5'd1, 5'd2, 5'd9, F3_ADD_SUB, c_add, 32'd1, 32'd1, 32'd0);
    ex_ready = 1'b1;
    tick();
    offer(32'h504, 5'd1, 5'd2, 5'd10, F3_ADD_SUB, c_add, 32'd1, 32'd1, 32'd0);
    ex_ready = 1'b0;
    flush    = 1'b1;
    tick();
    tests++; if (ex_valid !== 1'b0 || ex_ctrl !== CTRL_NOP || ex_rd !== 5'd0) begin fails++; $display("FAIL flush_bubble: got v=%0b ctrl=%h rd=%0d want 0 0 0", ex_valid, ex_ctrl, ex_rd); end
    flush    = 1'b0;
    id_valid = 1'b0;
    #1;
    tests++; if (id_ready !== 1'b1) begin fails++; $display("FAIL flush_empty_ready: got %0b want 1", id_ready); end
    tick();
  endtask

  task automatic test_back_to_back();
    ex_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      offer(32'h600 + 32'(4 * i), 5'd1, 5'd2, 5'(10 + i), F3_ADD_SUB, c_add, 32'(i), 32'd0, 32'd0);
      tick();
      tests++; if (ex_valid !== 1'b1 || ex_pc !== 32'h600 + 32'(4 * i) || ex_rd !== 5'(10 + i))
        begin fails++; $display("FAIL b2b[%0d]: got v=%0b pc=%h rd=%0d want 1 %h %0d", i, ex_valid, ex_pc, ex_rd, 32'h600 + 32'(4 * i), 10 + i); end
    end
    id_valid = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    offer(32'h700, 5'd2, 5'd0, 5'd5, F3_LW, c_lw, 32'h3000, 32'd0, 32'd0);
    ex_ready = 1'b1;
    tick();
    offer(32'h704, 5'd5, 5'd1, 5'd6, F3_ADD_SUB, c_add, 32'd0, 32'd0, 32'd0);
    ex_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    tests++; if (ex_valid !== 1'b0 || ex_pc !== 32'h0 || ex_rd !== 5'd0 || ex_ctrl !== CTRL_NOP)
      begin fails++; $display("FAIL async_rst_clear: got v=%0b pc=%h rd=%0d ctrl=%h want all 0", ex_valid, ex_pc, ex_rd, ex_ctrl); end
    tests++; if (hz_count !== 16'd0 || hz_stall !== 1'b0 || id_ready !== 1'b1)
      begin fails++; $display("FAIL async_rst_hz: got count=%0d stall=%0b ready=%0b want 0 0 1", hz_count, hz_stall, id_ready); end
    tick();
    rst      = 1'b0;
    ex_ready = 1'b1;
    tick();
    tests++; if (ex_valid !== 1'b1 || ex_pc !== 32'h704) begin fails++; $display("FAIL post_rst_capture: got v=%0b pc=%h want 1 704", ex_valid, ex_pc); end
    id_valid = 1'b0;
    tick();
  endtask

  initial begin
    c_add = '{reg_wen: 1'b1, mem_req: 1'b0, mem_rw: 1'b0, wb_sel: WB_ALU, alu_src: 1'b0,
              branch: 1'b0, jump: 1'b0, alu_op: ALU_ADD};
    c_lw  = '{reg_wen: 1'b1, mem_req: 1'b1, mem_rw: 1'b0, wb_sel: WB_MEM, alu_src: 1'b1,
              branch: 1'b0, jump: 1'b0, alu_op: ALU_ADD};
    rst         = 1'b1;
    id_valid    = 1'b0;
    id_pc       = '0;
    id_rs1_data = '0;
    id_rs2_data = '0;
    id_imm      = '0;
    id_rs1      = '0;
    id_rs2      = '0;
    id_rd       = '0;
    id_funct3   = '0;
    id_ctrl     = CTRL_NOP;
    flush       = 1'b0;
    ex_ready    = 1'b0;

    test_reset();
    test_add();
    test_backpressure();
    test_load_use();
    test_x0();
    test_flush();
    test_back_to_back();
    test_async_reset();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
